// File: rtl/cpu_trace_pkg.sv
// Shared constants, emitter state encoding and character helpers for the
// CPU write-back trace emitter.
package cpu_trace_pkg;

  localparam logic [7:0] ASC_CARET  = 8'h5E;
  localparam logic [7:0] ASC_AT     = 8'h40;
  localparam logic [7:0] ASC_COLON  = 8'h3A;
  localparam logic [7:0] ASC_SPACE  = 8'h20;
  localparam logic [7:0] ASC_DOLLAR = 8'h24;
  localparam logic [7:0] ASC_STAR   = 8'h2A;
  localparam logic [7:0] ASC_LT     = 8'h3C;
  localparam logic [7:0] ASC_EQ     = 8'h3D;
  localparam logic [7:0] ASC_HASH   = 8'h23;

  localparam int TIME_MAX = 9999;

  typedef enum logic [3:0] {
    S_IDLE, S_CONV, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP0,
    S_TAG, S_OPND, S_SP1, S_LT, S_EQ, S_SP2, S_DATA, S_HASH
  } emit_state_t;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic logic [7:0] dec_char(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  // Count of significant decimal digits; zero still prints one digit.
  function automatic logic [2:0] bcd_digits(input logic [15:0] bcd);
    if (bcd[15:12] != 4'd0)    return 3'd4;
    else if (bcd[11:8] != 4'd0) return 3'd3;
    else if (bcd[7:4] != 4'd0)  return 3'd2;
    else                        return 3'd1;
  endfunction

  function automatic emit_state_t next_emit(input emit_state_t s);
    case (s)
      S_CARET: return S_TIME;
      S_TIME:  return S_AT;
      S_AT:    return S_PC;
      S_PC:    return S_COLON;
      S_COLON: return S_SP0;
      S_SP0:   return S_TAG;
      S_TAG:   return S_OPND;
      S_OPND:  return S_SP1;
      S_SP1:   return S_LT;
      S_LT:    return S_EQ;
      S_EQ:    return S_SP2;
      S_SP2:   return S_DATA;
      S_DATA:  return S_HASH;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_trace_bin2dec.sv
// Iterative 14-bit binary to 4-digit BCD converter (shift-add-3, one bit per
// cycle), followed by one cycle that registers the significant digit count.
module cpu_trace_bin2dec
  import cpu_trace_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] value,
  output logic        done,
  output logic [15:0] bcd,
  output logic [2:0]  ndig
);

  logic [13:0] shreg;
  logic [15:0] adj;
  logic [3:0]  cnt;
  logic        busy;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // cnt reaching zero means all bits are in; the following cycle finalises.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= 4'd0;
      bcd   <= 16'd0;
      shreg <= 14'd0;
      ndig  <= 3'd1;
    end else if (start) begin
      busy  <= 1'b1;
      done  <= 1'b0;
      cnt   <= 4'd14;
      bcd   <= 16'd0;
      shreg <= value;
    end else if (busy) begin
      if (cnt != 4'd0) begin
        bcd   <= {adj[14:0], shreg[13]};
        shreg <= {shreg[12:0], 1'b0};
        cnt   <= cnt - 4'd1;
      end else begin
        busy <= 1'b0;
        done <= 1'b1;
        ndig <= bcd_digits(bcd);
      end
    end
  end

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serialises one register/memory write-back record into the ASCII trace line
// "^<time>@<pc>: $<grf>|*<addr> <= <data>#", one character per accepted beat.
module cpu_trace_emitter
  import cpu_trace_pkg::*;
#(
  parameter int TIME_W  = 14,
  parameter int HEX_LEN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rec_type,
  input  logic [TIME_W-1:0] time_i,
  input  logic [31:0]       pc_i,
  input  logic [4:0]        grf_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [7:0]        char,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              frame_done
);

  emit_state_t state, next_state;
  logic [3:0]  idx, next_idx;
  logic        last;
  logic        accept;

  logic        rec_r;
  logic [31:0] pc_r, addr_r, data_r;

  logic [13:0] time_sat;
  logic        time_done, grf_done;
  logic [15:0] time_bcd, grf_bcd;
  logic [2:0]  time_nd, grf_nd;
  logic [2:0]  tpos, gpos, hpos;

  assign accept   = in_valid && in_ready;
  assign time_sat = (time_i > TIME_W'(TIME_MAX)) ? 14'(TIME_MAX) : 14'(time_i);

  cpu_trace_bin2dec u_time_conv (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .value (time_sat),
    .done  (time_done),
    .bcd   (time_bcd),
    .ndig  (time_nd)
  );

  cpu_trace_bin2dec u_grf_conv (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .value ({9'd0, grf_i}),
    .done  (grf_done),
    .bcd   (grf_bcd),
    .ndig  (grf_nd)
  );

  // Digit position within a field: decimal fields print MSB-first over only
  // the significant digits, hex fields walk nibbles 7 down to 0.
  assign tpos = time_nd - 3'd1 - idx[2:0];
  assign gpos = grf_nd - 3'd1 - idx[2:0];
  assign hpos = 3'd7 - idx[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= 4'd0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rec_r  <= rec_type;
      pc_r   <= pc_i;
      addr_r <= addr_i;
      data_r <= data_i;
    end
  end

  always_comb begin
    next_state = state;
    next_idx   = idx;
    char       = 8'h00;
    char_valid = 1'b1;
    last       = 1'b1;
    in_ready   = (state == S_IDLE);
    case (state)
      S_IDLE: begin
        char_valid = 1'b0;
        if (in_valid) next_state = S_CONV;
      end
      S_CONV: begin
        char_valid = 1'b0;
        if (time_done && grf_done) next_state = S_CARET;
      end
      S_CARET: char = ASC_CARET;
      S_TIME: begin
        char = dec_char(time_bcd[{tpos[1:0], 2'b00} +: 4]);
        last = (idx[2:0] == time_nd - 3'd1);
      end
      S_AT: char = ASC_AT;
      S_PC: begin
        char = hex_char(pc_r[{hpos, 2'b00} +: 4]);
        last = (idx == 4'(HEX_LEN - 1));
      end
      S_COLON: char = ASC_COLON;
      S_SP0:   char = ASC_SPACE;
      S_TAG:   char = rec_r ? ASC_STAR : ASC_DOLLAR;
      S_OPND: begin
        if (rec_r) begin
          char = hex_char(addr_r[{hpos, 2'b00} +: 4]);
          last = (idx == 4'(HEX_LEN - 1));
        end else begin
          char = dec_char(grf_bcd[{gpos[1:0], 2'b00} +: 4]);
          last = (idx[2:0] == grf_nd - 3'd1);
        end
      end
      S_SP1: char = ASC_SPACE;
      S_LT:  char = ASC_LT;
      S_EQ:  char = ASC_EQ;
      S_SP2: char = ASC_SPACE;
      S_DATA: begin
        char = hex_char(data_r[{hpos, 2'b00} +: 4]);
        last = (idx == 4'(HEX_LEN - 1));
      end
      S_HASH:  char = ASC_HASH;
      default: char_valid = 1'b0;
    endcase
    if (char_valid && char_ready) begin
      if (last) begin
        next_state = next_emit(state);
        next_idx   = 4'd0;
      end else begin
        next_idx = idx + 4'd1;
      end
    end
    frame_done = (state == S_HASH) && char_ready;
  end

endmodule
